// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// master = upstream dispatch/CDB/ALU side, slave = the reservation station.
interface alu_rs_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic              disp_valid;
  logic              disp_ready;
  logic [3:0]        disp_ctrl;
  logic              disp_a_rdy;
  logic              disp_b_rdy;
  logic [DATA_W-1:0] disp_a_val;
  logic [DATA_W-1:0] disp_b_val;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [TAG_W-1:0]  disp_b_tag;
  logic [TAG_W-1:0]  disp_dst_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              iss_valid;
  logic              iss_ready;
  logic [3:0]        iss_ctrl;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [TAG_W-1:0]  iss_dst_tag;

  modport master (
    output disp_valid, disp_ctrl, disp_a_rdy, disp_b_rdy, disp_a_val, disp_b_val,
           disp_a_tag, disp_b_tag, disp_dst_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output iss_ready,
    input  disp_ready,
    input  iss_valid, iss_ctrl, iss_a, iss_b, iss_dst_tag
  );

  modport slave (
    input  disp_valid, disp_ctrl, disp_a_rdy, disp_b_rdy, disp_a_val, disp_b_val,
           disp_a_tag, disp_b_tag, disp_dst_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  iss_ready,
    output disp_ready,
    output iss_valid, iss_ctrl, iss_a, iss_b, iss_dst_tag
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station feeding the 32-bit ALU: holds renamed micro-ops until both
// operands are captured, issues the oldest ready one. Macro ALU_RS_WAKEUP_BYPASS_EN
// lets a CDB wakeup be selected in the same cycle, forwarding cdb_data into the slot.
module alu_rs #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  alu_rs_if.slave                  bus,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // A valid producer holds its payload stable until that edge; ready never waits on valid.

  logic [DEPTH-1:0]  ent_v;
  logic [DEPTH-1:0]  ent_a_rdy;
  logic [DEPTH-1:0]  ent_b_rdy;
  logic [3:0]        ent_ctrl  [DEPTH];
  logic [DATA_W-1:0] ent_a_val [DEPTH];
  logic [DATA_W-1:0] ent_b_val [DEPTH];
  logic [TAG_W-1:0]  ent_a_tag [DEPTH];
  logic [TAG_W-1:0]  ent_b_tag [DEPTH];
  logic [TAG_W-1:0]  ent_dst   [DEPTH];
  // older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older     [DEPTH];

  logic              iss_v_q;
  logic [3:0]        iss_ctrl_q;
  logic [DATA_W-1:0] iss_a_q;
  logic [DATA_W-1:0] iss_b_q;
  logic [TAG_W-1:0]  iss_dst_q;

  logic              disp_fire;
  logic              slot_open;
  logic [IDX_W-1:0]  alloc_idx;
  logic              disp_a_hit;
  logic              disp_b_hit;
  logic [DEPTH-1:0]  a_hit;
  logic [DEPTH-1:0]  b_hit;
  logic [DEPTH-1:0]  a_eff;
  logic [DEPTH-1:0]  b_eff;
  logic [DEPTH-1:0]  elig;
  logic [DEPTH-1:0]  sel_oh;
  logic              sel_any;
  logic [3:0]        sel_ctrl;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]  sel_dst;

  assign bus.disp_ready  = (occupancy < OCC_W'(DEPTH));
  assign disp_fire       = bus.disp_valid & bus.disp_ready;
  assign slot_open       = !iss_v_q | bus.iss_ready;

  assign bus.iss_valid   = iss_v_q;
  assign bus.iss_ctrl    = iss_ctrl_q;
  assign bus.iss_a       = iss_a_q;
  assign bus.iss_b       = iss_b_q;
  assign bus.iss_dst_tag = iss_dst_q;

  assign disp_a_hit = bus.cdb_valid & !bus.disp_a_rdy & (bus.disp_a_tag == bus.cdb_tag);
  assign disp_b_hit = bus.cdb_valid & !bus.disp_b_rdy & (bus.disp_b_tag == bus.cdb_tag);

  // Lowest-index free slot, taken from registered valid bits only
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_v[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    a_hit = '0;
    b_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a_hit[i] = ent_v[i] & bus.cdb_valid & !ent_a_rdy[i] & (ent_a_tag[i] == bus.cdb_tag);
      b_hit[i] = ent_v[i] & bus.cdb_valid & !ent_b_rdy[i] & (ent_b_tag[i] == bus.cdb_tag);
    end
  end

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  assign a_eff = ent_a_rdy | a_hit;
  assign b_eff = ent_b_rdy | b_hit;
`else
  assign a_eff = ent_a_rdy;
  assign b_eff = ent_b_rdy;
`endif

  assign elig = ent_v & a_eff & b_eff;

  // An eligible entry wins unless another eligible entry is older than it
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = elig[i] & slot_open;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && older[j][i]) sel_oh[i] = 1'b0;
      end
    end
  end

  assign sel_any = |sel_oh;

  always_comb begin
    sel_ctrl = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_dst  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        sel_ctrl = ent_ctrl[i];
        sel_dst  = ent_dst[i];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        sel_a    = ent_a_rdy[i] ? ent_a_val[i] : bus.cdb_data;
        sel_b    = ent_b_rdy[i] ? ent_b_val[i] : bus.cdb_data;
`else
        sel_a    = ent_a_val[i];
        sel_b    = ent_b_val[i];
`endif
      end
    end
  end

  // Entry control state: valid/ready bits and the age matrix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v     <= '0;
      ent_a_rdy <= '0;
      ent_b_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      ent_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_oh[i]) ent_v[i]     <= 1'b0;
        if (a_hit[i])  ent_a_rdy[i] <= 1'b1;
        if (b_hit[i])  ent_b_rdy[i] <= 1'b1;
      end
      if (disp_fire) begin
        ent_v[alloc_idx]     <= 1'b1;
        ent_a_rdy[alloc_idx] <= bus.disp_a_rdy | disp_a_hit;
        ent_b_rdy[alloc_idx] <= bus.disp_b_rdy | disp_b_hit;
        // New entry is younger than every entry still resident
        older[alloc_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) older[j][alloc_idx] <= ent_v[j];
      end
    end
  end

  // Payload carries no reset; it is qualified by the valid/ready bits above
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (a_hit[i]) ent_a_val[i] <= bus.cdb_data;
      if (b_hit[i]) ent_b_val[i] <= bus.cdb_data;
    end
    if (disp_fire) begin
      ent_ctrl[alloc_idx]  <= bus.disp_ctrl;
      ent_dst[alloc_idx]   <= bus.disp_dst_tag;
      ent_a_tag[alloc_idx] <= bus.disp_a_tag;
      ent_b_tag[alloc_idx] <= bus.disp_b_tag;
      ent_a_val[alloc_idx] <= bus.disp_a_rdy ? bus.disp_a_val : bus.cdb_data;
      ent_b_val[alloc_idx] <= bus.disp_b_rdy ? bus.disp_b_val : bus.cdb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(sel_any);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v_q    <= 1'b0;
      iss_ctrl_q <= '0;
      iss_a_q    <= '0;
      iss_b_q    <= '0;
      iss_dst_q  <= '0;
    end else if (flush) begin
      iss_v_q <= 1'b0;
    end else if (slot_open) begin
      iss_v_q <= sel_any;
      if (sel_any) begin
        iss_ctrl_q <= sel_ctrl;
        iss_a_q    <= sel_a;
        iss_b_q    <= sel_b;
        iss_dst_q  <= sel_dst;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: queue-based reference model checked every cycle, directed
// vectors with hand-computed issue results, both ALU_RS_WAKEUP_BYPASS_EN builds.
module tb_alu_rs;

  localparam int DEPTH = 4;

  typedef logic [73:0] cv_t;
  typedef struct packed {
    logic [3:0]  ctrl;
    logic        ar;
    logic        br;
    logic [31:0] av;
    logic [31:0] bv;
    logic [5:0]  at;
    logic [5:0]  bt;
    logic [5:0]  dt;
  } op_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] occupancy;

  alu_rs_if #(.TAG_W(6), .DATA_W(32)) bus ();

  alu_rs #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  op_t         mq[$];
  logic        m_v;
  op_t         m_slot;
  logic [73:0] exp_q[$];

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic next();
    @(negedge clk);
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic drive_disp(input int c, input int ar, input int av, input int at,
                            input int br, input int bv, input int bt, input int dt);
    bus.disp_valid   = 1'b1;
    bus.disp_ctrl    = 4'(c);
    bus.disp_a_rdy   = 1'(ar);
    bus.disp_a_val   = 32'(av);
    bus.disp_a_tag   = 6'(at);
    bus.disp_b_rdy   = 1'(br);
    bus.disp_b_val   = 32'(bv);
    bus.disp_b_tag   = 6'(bt);
    bus.disp_dst_tag = 6'(dt);
  endtask

  task automatic drive_cdb(input int t, input int d);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'(t);
    bus.cdb_data  = 32'(d);
  endtask

  task automatic expect_op(input int c, input int dt, input int av, input int bv);
    exp_q.push_back({4'(c), 6'(dt), 32'(av), 32'(bv)});
  endtask

  // scoreboard: every op the model hands to the ALU must match the next literal
  task automatic sb_accept(input op_t o);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected_issue actual=%0h expected=none", {o.ctrl, o.dt, o.av, o.bv});
    end else begin
      check("sb_issue", cv_t'({o.ctrl, o.dt, o.av, o.bv}), cv_t'(exp_q.pop_front()));
    end
  endtask

  function automatic logic cdb_hits(input logic rdy, input logic [5:0] tag);
    return !rdy && bus.cdb_valid && (tag == bus.cdb_tag);
  endfunction

  function automatic logic eligible(input op_t o);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    return (o.ar || cdb_hits(o.ar, o.at)) && (o.br || cdb_hits(o.br, o.bt));
`else
    return o.ar && o.br;
`endif
  endfunction

  // Reference model: ops kept in dispatch order; oldest eligible op moves to the slot
  task automatic model_step();
    int  pick;
    op_t o;
    logic fire;
    if (flush) begin
      mq.delete();
      m_v = 1'b0;
      return;
    end
    fire = bus.disp_valid && (mq.size() < DEPTH);
    if (m_v && bus.iss_ready) sb_accept(m_slot);
    if (!m_v || bus.iss_ready) begin
      pick = -1;
      for (int k = 0; k < mq.size(); k++)
        if (pick < 0 && eligible(mq[k])) pick = k;
      m_v = (pick >= 0);
      if (pick >= 0) begin
        o = mq[pick];
        if (!o.ar) o.av = bus.cdb_data;
        if (!o.br) o.bv = bus.cdb_data;
        m_slot = o;
        mq.delete(pick);
      end
    end
    for (int k = 0; k < mq.size(); k++) begin
      o = mq[k];
      if (cdb_hits(o.ar, o.at)) begin o.ar = 1'b1; o.av = bus.cdb_data; end
      if (cdb_hits(o.br, o.bt)) begin o.br = 1'b1; o.bv = bus.cdb_data; end
      mq[k] = o;
    end
    if (fire) begin
      o.ctrl = bus.disp_ctrl;
      o.ar = bus.disp_a_rdy;  o.av = bus.disp_a_val;  o.at = bus.disp_a_tag;
      o.br = bus.disp_b_rdy;  o.bv = bus.disp_b_val;  o.bt = bus.disp_b_tag;
      o.dt = bus.disp_dst_tag;
      if (cdb_hits(o.ar, o.at)) begin o.ar = 1'b1; o.av = bus.cdb_data; end
      if (cdb_hits(o.br, o.bt)) begin o.br = 1'b1; o.bv = bus.cdb_data; end
      mq.push_back(o);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_v    = 1'b0;
        m_slot = '0;
      end else begin
        model_step();
      end
    end
  end

  // per-cycle compare of DUT outputs against the model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("cyc_iss_valid", cv_t'(bus.iss_valid), cv_t'(m_v));
        check("cyc_occupancy", cv_t'(occupancy), cv_t'(mq.size()));
        check("cyc_disp_ready", cv_t'(bus.disp_ready), cv_t'(mq.size() < DEPTH));
        if (m_v)
          check("cyc_iss_payload",
                cv_t'({bus.iss_ctrl, bus.iss_dst_tag, bus.iss_a, bus.iss_b}),
                cv_t'({m_slot.ctrl, m_slot.dt, m_slot.av, m_slot.bv}));
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.iss_ready = 1'b1;
    drive_disp(0, 0, 0, 0, 0, 0, 0, 0);
    bus.disp_valid = 1'b0;
    drive_cdb(0, 0);
    bus.cdb_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_iss_valid", cv_t'(bus.iss_valid), cv_t'(0));
    check("rst_iss_fields", cv_t'({bus.iss_ctrl, bus.iss_dst_tag, bus.iss_a, bus.iss_b}), cv_t'(0));
    check("rst_occupancy", cv_t'(occupancy), cv_t'(0));
    rst_n = 1'b1;
    check("rst_disp_ready", cv_t'(bus.disp_ready), cv_t'(1));
    next();

    // basic ready dispatch: iss_valid two cycles later
    expect_op(2, 3, 5, 7);
    drive_disp(2, 1, 5, 0, 1, 7, 0, 3);
    next();
    check("t1_occ_after_disp", cv_t'(occupancy), cv_t'(1));
    check("t1_not_yet_valid", cv_t'(bus.iss_valid), cv_t'(0));
    next();
    check("t1_iss_valid", cv_t'(bus.iss_valid), cv_t'(1));
    check("t1_iss_payload", cv_t'({bus.iss_ctrl, bus.iss_dst_tag, bus.iss_a, bus.iss_b}),
          cv_t'({4'd2, 6'd3, 32'd5, 32'd7}));
    check("t1_occ_zero", cv_t'(occupancy), cv_t'(0));
    next();
    check("t1_drained", cv_t'(bus.iss_valid), cv_t'(0));

    // fill, drop when full, selective wakeup
    for (int i = 0; i < 4; i++) begin
      drive_disp(i, 0, 0, 10 + i, 1, 100 + i, 0, 20 + i);
      next();
    end
    check("t2_full_occ", cv_t'(occupancy), cv_t'(4));
    check("t2_full_ready", cv_t'(bus.disp_ready), cv_t'(0));
    drive_disp(9, 1, 1, 0, 1, 1, 0, 63);
    next();
    check("t2_dropped", cv_t'(occupancy), cv_t'(4));
    drive_cdb(40, 'h1234);
    next();
    next();
    check("t2_nomatch_occ", cv_t'(occupancy), cv_t'(4));
    check("t2_nomatch_valid", cv_t'(bus.iss_valid), cv_t'(0));
    expect_op(2, 22, 99, 102);
    expect_op(3, 23, 'h33, 103);
    expect_op(0, 20, 'h10, 100);
    expect_op(1, 21, 'h11, 101);
    drive_cdb(12, 99);
    next();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
    next();
`endif
    check("t2_tag12_issue", cv_t'({bus.iss_valid, bus.iss_ctrl, bus.iss_dst_tag, bus.iss_a, bus.iss_b}),
          cv_t'({1'b1, 4'd2, 6'd22, 32'd99, 32'd102}));
    check("t2_occ3", cv_t'(occupancy), cv_t'(3));
    drive_cdb(13, 'h33);
    next();
    drive_cdb(10, 'h10);
    next();
    drive_cdb(11, 'h11);
    next();
    repeat (4) next();
    check("t2_empty", cv_t'(occupancy), cv_t'(0));

    // age order independent of entry index: P lands in entry 2, Q in entry 0
    expect_op(6, 42, 'h32, 202);
    expect_op(4, 40, 'h30, 200);
    expect_op(7, 43, 'h40, 203);
    expect_op(8, 44, 'h40, 204);
    expect_op(5, 41, 'h31, 201);
    drive_disp(4, 0, 0, 30, 1, 200, 0, 40); next();
    drive_disp(5, 0, 0, 31, 1, 201, 0, 41); next();
    drive_disp(6, 0, 0, 32, 1, 202, 0, 42); next();
    drive_cdb(32, 'h32); next(); next(); next();
    drive_disp(7, 0, 0, 40, 1, 203, 0, 43); next();
    drive_cdb(30, 'h30); next(); next(); next();
    drive_disp(8, 0, 0, 40, 1, 204, 0, 44); next();
    drive_cdb(40, 'h40);
    next();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
    next();
`endif
    check("t3_oldest_first", cv_t'({bus.iss_valid, bus.iss_dst_tag, bus.iss_a}),
          cv_t'({1'b1, 6'd43, 32'h40}));
    next();
    check("t3_younger_next", cv_t'({bus.iss_valid, bus.iss_dst_tag, bus.iss_b}),
          cv_t'({1'b1, 6'd44, 32'd204}));
    drive_cdb(31, 'h31);
    next();
    repeat (4) next();
    check("t3_empty", cv_t'(occupancy), cv_t'(0));

    // back-pressure hold then back-to-back issue
    bus.iss_ready = 1'b0;
    expect_op(1, 50, 'h111, 'h222);
    expect_op(3, 51, 'h333, 'h444);
    drive_disp(1, 1, 'h111, 0, 1, 'h222, 0, 50); next();
    drive_disp(3, 1, 'h333, 0, 1, 'h444, 0, 51); next();
    for (int i = 0; i < 3; i++) begin
      check("t4_hold", cv_t'({bus.iss_valid, bus.iss_ctrl, bus.iss_dst_tag, bus.iss_a, bus.iss_b}),
            cv_t'({1'b1, 4'd1, 6'd50, 32'h111, 32'h222}));
      check("t4_hold_occ", cv_t'(occupancy), cv_t'(1));
      next();
    end
    bus.iss_ready = 1'b1;
    next();
    check("t4_second", cv_t'({bus.iss_valid, bus.iss_dst_tag, bus.iss_a}),
          cv_t'({1'b1, 6'd51, 32'h333}));
    check("t4_occ0", cv_t'(occupancy), cv_t'(0));
    next();
    check("t4_drained", cv_t'(bus.iss_valid), cv_t'(0));

    // dispatch-time CDB capture
    expect_op(9, 52, 1, 'hDEADBEEF);
    drive_disp(9, 1, 1, 0, 0, 0, 9, 52);
    drive_cdb(9, 'hDEADBEEF);
    next();
    next();
    check("t5_capture", cv_t'({bus.iss_valid, bus.iss_ctrl, bus.iss_dst_tag, bus.iss_b}),
          cv_t'({1'b1, 4'd9, 6'd52, 32'hDEADBEEF}));
    next();

    // wakeup-to-issue latency
    bus.iss_ready = 1'b0;
    expect_op(5, 53, 'h55, 'h77);
    drive_disp(5, 0, 0, 55, 1, 'h77, 0, 53);
    next();
    next();
    check("t5_waiting", cv_t'(bus.iss_valid), cv_t'(0));
    drive_cdb(55, 'h55);
    next();
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    check("t5_lat_n1", cv_t'(bus.iss_valid), cv_t'(1));
`else
    check("t5_lat_n1", cv_t'(bus.iss_valid), cv_t'(0));
`endif
    next();
    check("t5_lat_n2", cv_t'({bus.iss_valid, bus.iss_a}), cv_t'({1'b1, 32'h55}));
    bus.iss_ready = 1'b1;
    next();
    check("t5_drained", cv_t'(bus.iss_valid), cv_t'(0));

    // flush with three resident entries and a held issue slot
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_disp(i, 1, i, 0, 1, i + 1, 0, 60 + i);
      next();
    end
    check("t6_pre_occ", cv_t'(occupancy), cv_t'(3));
    check("t6_pre_valid", cv_t'({bus.iss_valid, bus.iss_dst_tag}), cv_t'({1'b1, 6'd60}));
    flush = 1'b1;
    drive_disp(9, 1, 9, 0, 1, 9, 0, 9);
    drive_cdb(1, 1);
    next();
    check("t6_flush_occ", cv_t'(occupancy), cv_t'(0));
    check("t6_flush_valid", cv_t'(bus.iss_valid), cv_t'(0));
    check("t6_flush_ready", cv_t'(bus.disp_ready), cv_t'(1));
    next();
    check("t6_flush_discard", cv_t'({bus.iss_valid, occupancy}), cv_t'(0));

    // asynchronous reset between edges
    drive_disp(2, 1, 'hAA, 0, 1, 'hBB, 0, 33); next();
    drive_disp(3, 0, 0, 20, 1, 1, 0, 34); next();
    check("t7_pre_valid", cv_t'({bus.iss_valid, occupancy}), cv_t'({1'b1, 3'd1}));
    #3;
    rst_n = 1'b0;
    #1;
    check("t7_async_valid", cv_t'(bus.iss_valid), cv_t'(0));
    check("t7_async_fields", cv_t'({bus.iss_ctrl, bus.iss_dst_tag, bus.iss_a, bus.iss_b}), cv_t'(0));
    check("t7_async_occ", cv_t'(occupancy), cv_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.iss_ready = 1'b1;
    next();
    next();
    check("t7_post_state", cv_t'({bus.iss_valid, bus.disp_ready, occupancy}), cv_t'({1'b0, 1'b1, 3'd0}));

    check("sb_all_issued", cv_t'(exp_q.size()), cv_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the 32-bit ALU in the out-of-order integer pipe.
- Accepts dispatched ALU micro-ops with renamed source operands and holds them until both operands are available. Operands arrive either at dispatch or by capture from the common data bus (CDB).
- Issues the oldest ready micro-op through a registered valid/ready port that drives the ALU A, B and CONTROL inputs plus the destination tag.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, operand width; matches the ALU.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_ctrl  in  4  ALU CONTROL code (0000..1001).
- disp_a_rdy, disp_b_rdy  in  1  operand value already valid.
- disp_a_val, disp_b_val  in  DATA_W  operand values.
- disp_a_tag, disp_b_tag  in  TAG_W  producer tags when not ready.
- disp_dst_tag  in  TAG_W  destination tag.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- iss_valid  out  1  issue slot holds a micro-op.
- iss_ready  in  1  ALU stage accepts.
- iss_ctrl  out  4  to ALU CONTROL.
- iss_a, iss_b  out  DATA_W  to ALU A and B.
- iss_dst_tag  out  TAG_W  destination tag.
- occupancy  out  clog2(DEPTH)+1  valid entry count.

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid.
  - iss_valid=0; iss_ctrl, iss_a, iss_b, iss_dst_tag = 0.
  - occupancy=0; disp_ready=1 after reset release.
- Dispatch:
  - Fires when disp_valid & disp_ready.
  - Writes the lowest-index free entry; the entry is valid from the next cycle.
  - disp_ready is a function of registered occupancy only (occupancy<DEPTH). A slot freed by selection in the same cycle is not reusable until the next cycle.
- Dispatch-time capture:
  - If an operand is not ready and cdb_valid with cdb_tag equal to its tag in the fire cycle, the entry stores cdb_data and marks the operand ready.
  - This is mandatory; no wakeup may be lost.
- Wakeup:
  - Every valid entry compares each not-ready operand tag with cdb_tag when cdb_valid.
  - On match, it captures cdb_data and sets ready at the clock edge.
  - One broadcast can wake any number of operands.
- Select:
  - Each cycle, among valid entries with both operands ready, pick the oldest in dispatch order. Ordering is kept by an age matrix; entry index is irrelevant to ordering.
  - Selection occurs only when the issue slot is empty or being drained (!iss_valid | iss_ready).
  - The selected entry is freed and the issue slot is loaded at the edge.
- Issue slot:
  - iss_* are held stable while iss_valid & !iss_ready.
  - Back-to-back issue is sustained at 1 per cycle.
- Latency (no CDB wait): dispatch in cycle N, entry valid N+1, iss_valid in N+2.
- Occupancy: +1 on dispatch fire, -1 on select, net 0 when both occur in the same cycle.
- Flush:
  - The next edge clears all entries and the issue slot (iss_valid=0).
  - Dispatch, wakeup and select in the flush cycle are discarded.
  - Flush has priority over everything except reset.
- Boundaries:
  - Full: disp_ready=0; disp_valid is ignored.
  - Empty: iss_valid falls after the last accept.
  - CDB tag matching no entry: no effect.
  - disp_ctrl is passed unchanged; no decode or legality check.
  - Reset asserted mid-operation clears everything immediately; there is no partial state.

Optional Feature:
- Macro: ALU_RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry whose last missing operand matches the CDB in cycle N is eligible for selection in cycle N.
  - The CDB value is forwarded directly into the issue slot, so iss_valid rises in N+1.
- Undefined:
  - The same entry becomes eligible in N+1 and iss_valid rises in N+2.
  - Select uses only registered ready bits.
- Functional results are identical either way; only latency differs.

Test Plan:
- Reset then dispatch ctrl=0010, a=5, b=7, both ready, dst=3, iss_ready=1 -> iss_valid 2 cycles later with iss_a=5, iss_b=7, iss_ctrl=0010, iss_dst_tag=3; occupancy back to 0.
- Dispatch 4 ops, each with operand A waiting on tags 10..13, so occupancy=4 -> disp_ready=0. A 5th disp_valid is dropped. CDB tag 12 data 99 -> only the op waiting on tag 12 issues, with iss_a=99.
- Two ready ops dispatched into entries 2 then 0 (entry 0 freed earlier) -> entry 2's op issues first (oldest), then entry 0's.
- Hold iss_ready=0 for 3 cycles with 2 ready ops -> iss_* stable, occupancy=1; release -> both issue on consecutive cycles.
- Dispatch operand B tag 9 in the same cycle as CDB tag 9 data 0xDEAD_BEEF -> captured; iss_b=0xDEADBEEF. Also check the ALU_RS_WAKEUP_BYPASS_EN latency difference (N+1 defined vs N+2 undefined) on a CDB-woken entry.
- Flush with 3 entries valid and iss_valid=1 -> next cycle occupancy=0, iss_valid=0. Assert rst_n=0 mid-cycle -> outputs zero immediately, with no clock edge.
